// File: rtl/motion_pkg.sv
// Shared motion-control types: quadrature step classification and the {A,B} transition decoder.
package motion_pkg;

   typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} quad_step_t;

   // Position of an {A,B} pair around the forward cycle 00->10->11->01->00.
   function automatic logic [1:0] quad_phase(input logic [1:0] ab);
      logic [1:0] phase;
      case (ab)
         2'b00:   phase = 2'd0;
         2'b10:   phase = 2'd1;
         2'b11:   phase = 2'd2;
         default: phase = 2'd3;
      endcase
      return phase;
   endfunction

   function automatic quad_step_t quad_decode(input logic [1:0] prev, input logic [1:0] curr);
      logic [1:0] delta;
      quad_step_t step;
      delta = quad_phase(curr) - quad_phase(prev);
      case (delta)
         2'd0:    step = STEP_NONE;
         2'd1:    step = STEP_FWD;
         2'd3:    step = STEP_REV;
         default: step = STEP_ERR;
      endcase
      return step;
   endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder-side inputs and register-file-facing outputs of one motor channel's quadrature decoder.
interface quadrature_decoder_if #(
   parameter int COUNT_WIDTH = 32
);
   logic                   sync_a;
   logic                   sync_b;
   logic                   sync_index;
   logic                   enable;
   logic                   clear_count;
   logic                   clear_error;
   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] index_count;
   logic                   direction;
   logic                   count_pulse;
   logic                   index_pulse;
   logic                   error;

   modport master (
      output sync_a, sync_b, sync_index, enable, clear_count, clear_error,
      input  count, index_count, direction, count_pulse, index_pulse, error
   );

   modport slave (
      input  sync_a, sync_b, sync_index, enable, clear_count, clear_error,
      output count, index_count, direction, count_pulse, index_pulse, error
   );
endinterface

// File: rtl/glitch_filter.sv
// Debounces one synchronised encoder line: the output follows the input only after it has
// differed for FILTER_CYCLES consecutive clocks. reset is active-low.
module glitch_filter #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);
   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;

   // The counter holds the number of mismatching samples already seen, so the
   // FILTER_CYCLES-th consecutive mismatch flips the output on that same edge.
   always_comb begin
      out_d = out_q;
      cnt_d = '0;
      if (in != out_q) begin
         if (cnt_q == LAST) begin
            out_d = ~out_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Glitch-filtered 4x quadrature decoder with signed position count, index capture and sticky
// illegal-transition flag. reset is asynchronous and active-low.
module quadrature_decoder
   import motion_pkg::*;
#(
   parameter int COUNT_WIDTH   = 32,
   parameter int FILTER_CYCLES = 4,
   parameter bit INDEX_CLEAR   = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   quadrature_decoder_if.slave bus
);
   localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

   logic                   filtA, filtB;
   logic [1:0]             prevAb_q;
   logic                   syncIndex_q;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [COUNT_WIDTH-1:0] indexCount_q, indexCount_d;
   logic                   direction_q, direction_d;
   logic                   countPulse_q, countPulse_d;
   logic                   indexPulse_q, indexPulse_d;
   logic                   error_q, error_d;
   quad_step_t             step;
   logic                   stepValid;
   logic                   indexEdge;

   glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filterA (
      .clk   (clk),
      .reset (reset),
      .in    (bus.sync_a),
      .out   (filtA)
   );

   glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filterB (
      .clk   (clk),
      .reset (reset),
      .in    (bus.sync_b),
      .out   (filtB)
   );

   always_comb begin
      step      = quad_decode(prevAb_q, {filtA, filtB});
      indexEdge = bus.sync_index & ~syncIndex_q;
      stepValid = bus.enable && ((step == STEP_FWD) || (step == STEP_REV));

      count_d      = count_q;
      indexCount_d = indexCount_q;
      direction_d  = direction_q;
      countPulse_d = stepValid;
      indexPulse_d = indexEdge;
      error_d      = error_q;

      if (stepValid) begin
         direction_d = (step == STEP_FWD);
      end

      // A clear swallows a coincident step's count change, yet its strobe and direction still go out.
      if (bus.clear_count) begin
         count_d = '0;
      end else if (INDEX_CLEAR && indexEdge) begin
         count_d = '0;
      end else if (stepValid) begin
         count_d = (step == STEP_FWD) ? count_q + ONE : count_q - ONE;
      end

      if (indexEdge) begin
         indexCount_d = count_q;
      end

      if (step == STEP_ERR) begin
         error_d = 1'b1;
      end else if (bus.clear_error) begin
         error_d = 1'b0;
      end
   end

   // prevAb_q tracks the filtered lines even while counting is disabled, so re-enabling
   // never produces a stale step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prevAb_q     <= 2'b00;
         syncIndex_q  <= 1'b0;
         count_q      <= '0;
         indexCount_q <= '0;
         direction_q  <= 1'b0;
         countPulse_q <= 1'b0;
         indexPulse_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         prevAb_q     <= {filtA, filtB};
         syncIndex_q  <= bus.sync_index;
         count_q      <= count_d;
         indexCount_q <= indexCount_d;
         direction_q  <= direction_d;
         countPulse_q <= countPulse_d;
         indexPulse_q <= indexPulse_d;
         error_q      <= error_d;
      end
   end

   assign bus.count       = count_q;
   assign bus.index_count = indexCount_q;
   assign bus.direction   = direction_q;
   assign bus.count_pulse = countPulse_q;
   assign bus.index_pulse = indexPulse_q;
   assign bus.error       = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: a 32-bit plain instance and an 8-bit INDEX_CLEAR
// instance share one stimulus stream; expected step results are queued when edges are driven.
module tb_quadrature_decoder;

   localparam int CW      = 32;
   localparam int CW2     = 8;
   localparam int FC      = 4;
   localparam int LATENCY = FC + 1;

   typedef struct {
      logic [CW-1:0] cnt;
      logic          dir;
      int            due;
   } expect_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   quadrature_decoder_if #(.COUNT_WIDTH(CW))  bus0 ();
   quadrature_decoder_if #(.COUNT_WIDTH(CW2)) bus1 ();

   quadrature_decoder #(.COUNT_WIDTH(CW), .FILTER_CYCLES(FC), .INDEX_CLEAR(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   quadrature_decoder #(.COUNT_WIDTH(CW2), .FILTER_CYCLES(FC), .INDEX_CLEAR(1'b1)) dutIdx (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   assign bus1.sync_a      = bus0.sync_a;
   assign bus1.sync_b      = bus0.sync_b;
   assign bus1.sync_index  = bus0.sync_index;
   assign bus1.enable      = bus0.enable;
   assign bus1.clear_count = bus0.clear_count;
   assign bus1.clear_error = bus0.clear_error;

   expect_t        sb[$];
   expect_t        popped;
   int             vectors     = 0;
   int             miscompares = 0;
   int             cycleCnt    = 0;
   int             pulsesSeen  = 0;
   int             pos         = 0;
   logic [CW-1:0]  expCount    = '0;
   logic [CW2-1:0] expCount2   = '0;
   logic           expDir      = 1'b0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] phaseAb(input int p);
      logic [1:0] ab;
      case (p)
         0:       ab = 2'b00;
         1:       ab = 2'b10;
         2:       ab = 2'b11;
         default: ab = 2'b01;
      endcase
      return ab;
   endfunction

   task automatic driveAb(input int advance);
      pos = (pos + advance) % 4;
      {bus0.sync_a, bus0.sync_b} = phaseAb(pos);
   endtask

   task automatic pushExpect(input logic dir);
      expect_t e;
      e.cnt = expCount;
      e.dir = dir;
      e.due = cycleCnt + LATENCY;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input bit fwd, input int gap);
      driveAb(fwd ? 1 : 3);
      if (bus0.enable) begin
         expCount  = fwd ? expCount + 32'd1 : expCount - 32'd1;
         expCount2 = fwd ? expCount2 + 8'd1 : expCount2 - 8'd1;
         expDir    = fwd;
         pushExpect(fwd);
      end
      waitCycles(gap);
   endtask

   task automatic clearCount();
      bus0.clear_count = 1'b1;
      waitCycles(1);
      bus0.clear_count = 1'b0;
      expCount  = '0;
      expCount2 = '0;
   endtask

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Every count_pulse must match the oldest queued step; overdue entries are reported.
   always @(negedge clk) begin
      if (reset) begin
         if (bus0.count_pulse) begin
            pulsesSeen++;
            if (sb.size() == 0) begin
               checkOutput("pulse_unexpected", bus0.count_pulse, 1'b0);
            end else begin
               popped = sb.pop_front();
               checkOutput("sb_count", bus0.count, popped.cnt);
               checkOutput("sb_dir", bus0.direction, popped.dir);
               checkOutput("sb_latency", cycleCnt, popped.due);
            end
         end else if (sb.size() != 0 && cycleCnt > sb[0].due) begin
            checkOutput("pulse_timeout", bus0.count_pulse, 1'b1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, %0d steps still queued", sb.size());
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus0.sync_a      = 1'b0;
      bus0.sync_b      = 1'b0;
      bus0.sync_index  = 1'b0;
      bus0.enable      = 1'b1;
      bus0.clear_count = 1'b0;
      bus0.clear_error = 1'b0;

      waitCycles(3);
      checkOutput("rst_count", bus0.count, 32'd0);
      checkOutput("rst_index_count", bus0.index_count, 32'd0);
      checkOutput("rst_direction", bus0.direction, 1'b0);
      checkOutput("rst_count_pulse", bus0.count_pulse, 1'b0);
      checkOutput("rst_index_pulse", bus0.index_pulse, 1'b0);
      checkOutput("rst_error", bus0.error, 1'b0);
      reset = 1'b1;
      waitCycles(2);

      $display("[TB] forward rotation, 32 edges");
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, 10);
      checkOutput("fwd_count", bus0.count, 32'd32);
      checkOutput("fwd_direction", bus0.direction, 1'b1);
      checkOutput("fwd_pulses", pulsesSeen, 32'd32);

      $display("[TB] reverse through zero");
      clearCount();
      checkOutput("clear_count", bus0.count, expCount);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10);
      checkOutput("rev_wrap", bus0.count, 32'hFFFF_FFFD);
      checkOutput("rev_wrap_narrow", bus1.count, 8'hFD);
      checkOutput("rev_direction", bus0.direction, 1'b0);
      applyStimulus(1'b0, 10);

      $display("[TB] glitch rejection on A");
      bus0.sync_a = 1'b1;
      waitCycles(FC - 1);
      bus0.sync_a = 1'b0;
      waitCycles(10);
      checkOutput("glitch_rejected", bus0.count, expCount);
      bus0.sync_a = 1'b1;
      expCount  = expCount + 32'd1;
      expCount2 = expCount2 + 8'd1;
      pushExpect(1'b1);
      waitCycles(FC);
      bus0.sync_a = 1'b0;
      expCount  = expCount - 32'd1;
      expCount2 = expCount2 - 8'd1;
      expDir    = 1'b0;
      pushExpect(1'b0);
      waitCycles(10);
      checkOutput("glitch_pulse_net", bus0.count, 32'hFFFF_FFFC);

      $display("[TB] enable low holds count and direction");
      bus0.enable = 1'b0;
      applyStimulus(1'b1, 10);
      bus0.enable = 1'b1;
      checkOutput("disabled_count", bus0.count, expCount);
      checkOutput("disabled_direction", bus0.direction, expDir);

      $display("[TB] illegal double-bit transition");
      driveAb(2);
      waitCycles(10);
      checkOutput("err_set", bus0.error, 1'b1);
      checkOutput("err_count_held", bus0.count, expCount);
      bus0.clear_error = 1'b1;
      waitCycles(1);
      bus0.clear_error = 1'b0;
      checkOutput("err_cleared", bus0.error, 1'b0);
      driveAb(2);
      waitCycles(FC);
      bus0.clear_error = 1'b1;
      waitCycles(1);
      bus0.clear_error = 1'b0;
      checkOutput("err_beats_clear", bus0.error, 1'b1);
      bus0.clear_error = 1'b1;
      waitCycles(1);
      bus0.clear_error = 1'b0;
      checkOutput("err_recleared", bus0.error, 1'b0);

      $display("[TB] clear_count coincident with a step");
      driveAb(1);
      expCount  = '0;
      expCount2 = '0;
      expDir    = 1'b1;
      pushExpect(1'b1);
      waitCycles(FC);
      bus0.clear_count = 1'b1;
      waitCycles(1);
      bus0.clear_count = 1'b0;
      waitCycles(6);
      checkOutput("clear_step_count", bus0.count, 32'd0);
      checkOutput("clear_step_direction", bus0.direction, 1'b1);

      $display("[TB] index capture at count 100");
      for (int i = 0; i < 100; i++) applyStimulus(1'b1, 6);
      checkOutput("pre_index_count", bus0.count, 32'd100);
      bus0.sync_index = 1'b1;
      waitCycles(1);
      checkOutput("index_pulse", bus0.index_pulse, 1'b1);
      checkOutput("index_count", bus0.index_count, 32'd100);
      checkOutput("index_count_narrow", bus1.index_count, 8'd100);
      checkOutput("index_keeps_count", bus0.count, expCount);
      expCount2 = '0;
      checkOutput("index_clears_count", bus1.count, expCount2);
      waitCycles(1);
      checkOutput("index_pulse_one_cycle", bus0.index_pulse, 1'b0);
      bus0.sync_index = 1'b0;

      $display("[TB] positive-to-negative wrap on the narrow counter");
      for (int i = 0; i < 127; i++) applyStimulus(1'b1, 6);
      checkOutput("narrow_max_pos", bus1.count, 8'h7F);
      applyStimulus(1'b1, 6);
      checkOutput("narrow_wrap_neg", bus1.count, 8'h80);
      checkOutput("wide_after_wrap", bus0.count, 32'd228);

      $display("[TB] reset mid-rotation");
      driveAb(1);
      waitCycles(2);
      reset = 1'b0;
      #1;
      checkOutput("midrst_count", bus0.count, 32'd0);
      checkOutput("midrst_index_count", bus0.index_count, 32'd0);
      checkOutput("midrst_direction", bus0.direction, 1'b0);
      checkOutput("midrst_count_pulse", bus0.count_pulse, 1'b0);
      checkOutput("midrst_index_pulse", bus0.index_pulse, 1'b0);
      checkOutput("midrst_error", bus0.error, 1'b0);
      checkOutput("midrst_narrow_index", bus1.index_count, 8'd0);
      sb.delete();
      pos = 0;
      {bus0.sync_a, bus0.sync_b} = phaseAb(pos);
      expCount  = '0;
      expCount2 = '0;
      waitCycles(2);
      reset = 1'b1;
      waitCycles(8);
      checkOutput("post_rst_count", bus0.count, expCount);
      checkOutput("post_rst_narrow", bus1.count, expCount2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
